// File: rtl/mem_responder.sv
// Single-outstanding memory responder: a fixed-latency RAM plus a small MMIO window
// (scratch register and free-running cycle counter) behind a strobe/ready handshake.
module mem_responder #(
  parameter int A_WIDTH      = 32,
  parameter int M_DEPTH_LOG2 = 10,
  parameter int RD_LAT       = 2,
  parameter int WR_LAT       = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [A_WIDTH-1:0] m_a,
  input  logic [31:0]        m_din,
  input  logic               m_strobe,
  input  logic               m_rw,
  output logic [31:0]        m_dout,
  output logic               m_ready
);

  localparam logic [3:0] RD_CNT = 4'(RD_LAT);
  localparam logic [3:0] WR_CNT = 4'(WR_LAT);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                    state;
  logic [3:0]                wait_cnt;
  logic [A_WIDTH-1:0]        addr_q;
  logic [31:0]               din_q;
  logic                      rw_q;
  logic [31:0]               scratch;
  logic [31:0]               cycle_cnt;
  logic [31:0]               mem [0:(2**M_DEPTH_LOG2)-1];
  logic [31:0]               rd_data;
  logic                      is_mmio;
  logic [13:0]               mmio_off;
  logic [M_DEPTH_LOG2-1:0]   word_idx;
  logic                      unused_addr;

  assign is_mmio     = (addr_q[31:16] == 16'h1faf);
  assign mmio_off    = addr_q[15:2];
  assign word_idx    = addr_q[M_DEPTH_LOG2+1:2];
  assign unused_addr = ^addr_q[1:0];

  // The counter is sampled on the edge entering RESP, so add one to match its RESP-cycle value.
  always_comb begin
    rd_data = 32'h0;
    if (is_mmio) begin
      case (mmio_off)
        14'd0:   rd_data = scratch;
        14'd1:   rd_data = cycle_cnt + 32'd1;
        default: rd_data = 32'h0;
      endcase
    end else begin
      rd_data = mem[word_idx];
    end
  end

  // RAM is not reset; the write commits on the edge closing RESP, so a reset there aborts it.
  always_ff @(posedge clk) begin
    if (!rst && state == RESP && rw_q && !is_mmio)
      mem[word_idx] <= din_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      addr_q    <= '0;
      din_q     <= 32'h0;
      rw_q      <= 1'b0;
      scratch   <= 32'h0;
      cycle_cnt <= 32'h0;
      m_ready   <= 1'b0;
      m_dout    <= 32'h0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      case (state)
        IDLE: begin
          m_ready <= 1'b0;
          m_dout  <= 32'h0;
          if (m_strobe) begin
            addr_q   <= m_a;
            din_q    <= m_din;
            rw_q     <= m_rw;
            wait_cnt <= m_rw ? WR_CNT : RD_CNT;
            state    <= WAIT;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            state   <= RESP;
            m_ready <= 1'b1;
            m_dout  <= rw_q ? 32'h0 : rd_data;
          end
        end
        RESP: begin
          m_ready <= 1'b0;
          m_dout  <= 32'h0;
          state   <= IDLE;
          if (rw_q && is_mmio && mmio_off == 14'd0)
            scratch <= din_q;
        end
        default: begin
          state   <= IDLE;
          m_ready <= 1'b0;
          m_dout  <= 32'h0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: RAM/MMIO access, latency, aliasing, back-to-back
// requests and reset abort, all against hand-computed values.
module tb_mem_responder;

  logic        clk;
  logic        rst;
  logic [31:0] m_a;
  logic [31:0] m_din;
  logic        m_strobe;
  logic        m_rw;
  logic [31:0] m_dout;
  logic        m_ready;

  int          checks;
  int          passes;
  logic [31:0] tbCnt;

  mem_responder #(
    .A_WIDTH(32), .M_DEPTH_LOG2(10), .RD_LAT(2), .WR_LAT(1)
  ) dut (
    .clk(clk), .rst(rst), .m_a(m_a), .m_din(m_din), .m_strobe(m_strobe),
    .m_rw(m_rw), .m_dout(m_dout), .m_ready(m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference for the MMIO cycle counter: non-reset edges since the last reset edge.
  always @(posedge clk) begin
    if (rst) tbCnt <= 32'h0;
    else     tbCnt <= tbCnt + 32'd1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
  endtask

  // Issue one request in the current cycle, drop strobe the next cycle, wait for ready.
  task automatic applyStimulus(input string tag, input logic [31:0] addr, input logic [31:0] data,
                               input logic rw, input int lat,
                               output logic [31:0] rdata, output logic [31:0] cntAtReady);
    int i;
    m_a = addr; m_din = data; m_rw = rw; m_strobe = 1'b1;
    @(posedge clk); #1;
    m_strobe = 1'b0;
    m_din = 32'hDEAD_BEEF;
    i = 1;
    while (!m_ready && i < 20) begin
      @(posedge clk); #1;
      i++;
    end
    checkOutput({tag, "_latency"}, 32'(i), 32'(lat + 1));
    rdata = m_dout;
    cntAtReady = tbCnt;
    if (rw) checkOutput({tag, "_wr_dout"}, m_dout, 32'h0);
    @(posedge clk); #1;
    checkOutput({tag, "_ready_drop"}, {31'h0, m_ready}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] cnt;
    logic [31:0] d1, d2;
    int first, second, consec, readyHigh;
    logic prev;
    checks = 0; passes = 0;
    rst = 1'b1; m_a = 32'h0; m_din = 32'h0; m_strobe = 1'b0; m_rw = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ready", {31'h0, m_ready}, 32'h0);
    checkOutput("reset_dout", m_dout, 32'h0);
    rst = 1'b0;

    // First request lands in the very first cycle out of reset.
    applyStimulus("wr10", 32'h0000_0010, 32'h1234_5678, 1'b1, 1, rd, cnt);
    applyStimulus("rd10", 32'h0000_0010, 32'h0, 1'b0, 2, rd, cnt);
    checkOutput("rd10_data", rd, 32'h1234_5678);

    applyStimulus("wr1010", 32'h0000_1010, 32'hCAFE_0001, 1'b1, 1, rd, cnt);
    applyStimulus("rd_alias", 32'h0000_0010, 32'h0, 1'b0, 2, rd, cnt);
    checkOutput("alias_data", rd, 32'hCAFE_0001);

    applyStimulus("wr_scr", 32'h1faf_0000, 32'hA5A5_A5A5, 1'b1, 1, rd, cnt);
    applyStimulus("rd_scr", 32'h1faf_0000, 32'h0, 1'b0, 2, rd, cnt);
    checkOutput("scratch_data", rd, 32'hA5A5_A5A5);

    applyStimulus("wr_cnt", 32'h1faf_0004, 32'h0000_0000, 1'b1, 1, rd, cnt);
    applyStimulus("rd_cnt", 32'h1faf_0004, 32'h0, 1'b0, 2, rd, cnt);
    checkOutput("counter_data", rd, cnt);

    applyStimulus("wr_other", 32'h1faf_0008, 32'hFFFF_FFFF, 1'b1, 1, rd, cnt);
    applyStimulus("rd_other", 32'h1faf_0008, 32'h0, 1'b0, 2, rd, cnt);
    checkOutput("other_data", rd, 32'h0);

    // Strobe held high across two reads: second accepted in the IDLE cycle after RESP.
    m_a = 32'h0000_0010; m_rw = 1'b0; m_strobe = 1'b1;
    first = -1; second = -1; consec = 0; prev = 1'b0; d1 = 32'h0; d2 = 32'h0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (c == 5) m_strobe = 1'b0;
      if (m_ready) begin
        if (first < 0) begin first = c; d1 = m_dout; end
        else if (second < 0) begin second = c; d2 = m_dout; end
      end
      if (prev && m_ready) consec++;
      prev = m_ready;
    end
    checkOutput("b2b_first", 32'(first), 32'd3);
    checkOutput("b2b_spacing", 32'(second - first), 32'd4);
    checkOutput("b2b_consec", 32'(consec), 32'd0);
    checkOutput("b2b_data1", d1, 32'hCAFE_0001);
    checkOutput("b2b_data2", d2, 32'hCAFE_0001);

    applyStimulus("wr20", 32'h0000_0020, 32'h5A5A_0020, 1'b1, 1, rd, cnt);
    applyStimulus("rd20", 32'h0000_0020, 32'h0, 1'b0, 2, rd, cnt);
    checkOutput("rd20_data", rd, 32'h5A5A_0020);

    // Reset during WAIT kills the write and the ready pulse.
    m_a = 32'h0000_0020; m_din = 32'h1111_1111; m_rw = 1'b1; m_strobe = 1'b1;
    @(posedge clk); #1;
    m_strobe = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    readyHigh = 0;
    for (int c = 0; c < 5; c++) begin
      if (m_ready) readyHigh++;
      @(posedge clk); #1;
    end
    checkOutput("abort_no_ready", 32'(readyHigh), 32'd0);
    applyStimulus("rd_abort", 32'h0000_0020, 32'h0, 1'b0, 2, rd, cnt);
    checkOutput("abort_data", rd, 32'h5A5A_0020);
    applyStimulus("rd_scr_rst", 32'h1faf_0000, 32'h0, 1'b0, 2, rd, cnt);
    checkOutput("scratch_after_rst", rd, 32'h0);
    applyStimulus("rd_cnt_rst", 32'h1faf_0004, 32'h0, 1'b0, 2, rd, cnt);
    checkOutput("counter_after_rst", rd, cnt);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
